fsm_stim_driver: RTL and testbench

- Stimulus generator for the `testFSM` recognizer. It drives that FSM's `in1`/`in2`/`in3` inputs so the FSM walks to a commanded target state.
- Accepts target-state commands over a valid/ready handshake. Keeps a cycle-exact shadow copy of the partner state and emits one input vector per hop.
- Pulses `done` on arrival. Used in bring-up benches and as a scripted front-end for `testFSM` instances.

---
 rtl/fsm_stim_driver.sv | 136 +++++++++++++
 tb/tb_fsm_stim_driver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stim_driver.sv
// Stimulus driver that walks a testFSM partner to a commanded target state.
// Define FSM_STIM_CHECK_EN to compare the partner's Moore outputs against the shadow.
module fsm_stim_driver #(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_target,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out1,
  input  logic       out2,
  output logic       done,
  output logic [1:0] steps,
  output logic [1:0] shadow_state,
  output logic       mismatch
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] P_INIT  = 2'd0;
  localparam logic [1:0] P_READ1 = 2'd1;
  localparam logic [1:0] P_READ2 = 2'd2;
  localparam logic [1:0] P_READ3 = 2'd3;

  logic [1:0] state;
  logic [1:0] shadow;
  logic [1:0] shadow_nxt;
  logic [1:0] target;
  logic [1:0] steps_q;
  logic [3:0] gap_cnt;
  logic [2:0] vec;

  // Vector is decoded from registers only, so reset clears it without a clock.
  always_comb begin
    vec = '0;
    if (state == ST_STEP) begin
      case (shadow)
        P_INIT:  vec = (target == P_READ1) ? 3'b110 : 3'b100;
        P_READ1: vec = 3'b010;
        P_READ2: vec = 3'b001;
        default: vec = 3'b000;
      endcase
    end
  end

  assign {in1, in2, in3} = vec;

  always_comb begin
    shadow_nxt = shadow;
    case (shadow)
      P_INIT: begin
        if (vec[2] && vec[1])       shadow_nxt = P_READ1;
        else if (vec[2] && !vec[1]) shadow_nxt = P_READ2;
      end
      P_READ1: if (vec[1] && !vec[0]) shadow_nxt = P_INIT;
      P_READ2: if (|vec)              shadow_nxt = P_READ3;
      default:                        shadow_nxt = P_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= ST_IDLE;
      shadow  <= P_INIT;
      target  <= P_INIT;
      steps_q <= '0;
      gap_cnt <= '0;
    end else begin
      shadow <= shadow_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            target  <= cmd_target;
            steps_q <= '0;
            state   <= (cmd_target == shadow) ? ST_DONE : ST_STEP;
          end
        end
        ST_STEP: begin
          steps_q <= steps_q + 2'd1;
          if (shadow_nxt == target) begin
            state <= ST_DONE;
          end else if ((IDLE_GAP > 0) && (shadow_nxt != P_READ3)) begin
            // read3 exits on its own, so a gap there would desynchronise the shadow.
            state   <= ST_GAP;
            gap_cnt <= 4'(IDLE_GAP);
          end else begin
            state <= ST_STEP;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= ST_STEP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state == ST_IDLE);
  assign done         = (state == ST_DONE);
  assign steps        = steps_q;
  assign shadow_state = shadow;

`ifdef FSM_STIM_CHECK_EN
  logic [1:0] exp_code;
  logic       mismatch_q;

  always_comb begin
    exp_code = 2'b11;
    case (shadow)
      P_INIT:  exp_code = 2'b10;
      P_READ1: exp_code = 2'b01;
      default: exp_code = 2'b11;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) mismatch_q <= 1'b0;
    else if ({out1, out2} != exp_code) mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`else
  logic unused_outs;
  assign unused_outs = out1 ^ out2;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Randomized self-checking bench for fsm_stim_driver; dut a has no gap, dut b has IDLE_GAP=2.
module tb_fsm_stim_driver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_L;
  logic       a_valid, a_ready, a_in1, a_in2, a_in3, a_out1, a_out2, a_done, a_mm;
  logic [1:0] a_target, a_steps, a_shadow;
  logic       b_valid, b_ready, b_in1, b_in2, b_in3, b_out1, b_out2, b_done, b_mm;
  logic [1:0] b_target, b_steps, b_shadow;
  logic       force_a;

  int errors = 0;
  int checks = 0;
  int ms[2];
  int pa, pb;
  logic [2:0] exp_q[$];

  fsm_stim_driver #(.IDLE_GAP(0)) dut_a (
    .clock(clock), .reset_L(reset_L), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_target(a_target), .in1(a_in1), .in2(a_in2), .in3(a_in3),
    .out1(a_out1), .out2(a_out2), .done(a_done), .steps(a_steps),
    .shadow_state(a_shadow), .mismatch(a_mm)
  );

  fsm_stim_driver #(.IDLE_GAP(2)) dut_b (
    .clock(clock), .reset_L(reset_L), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_target(b_target), .in1(b_in1), .in2(b_in2), .in3(b_in3),
    .out1(b_out1), .out2(b_out2), .done(b_done), .steps(b_steps),
    .shadow_state(b_shadow), .mismatch(b_mm)
  );

  // Partner protocol rules: next partner state from current state and input vector.
  function automatic int partner_step(int st, logic [2:0] v);
    case (st)
      0: return (v[2] && v[1]) ? 1 : ((v[2] && !v[1]) ? 2 : 0);
      1: return (v[1] && !v[0]) ? 0 : 1;
      2: return (v != 3'b000) ? 3 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] hop(int st, int tgt);
    case (st)
      0: return (tgt == 1) ? 3'b110 : 3'b100;
      1: return 3'b010;
      2: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Behavioural partners feeding the Moore outputs back.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pa <= 0;
      pb <= 0;
    end else begin
      pa <= partner_step(pa, {a_in1, a_in2, a_in3});
      pb <= partner_step(pb, {b_in1, b_in2, b_in3});
    end
  end
  assign a_out1 = (pa != 1) | force_a;
  assign a_out2 = (pa != 0);
  assign b_out1 = (pb != 1);
  assign b_out2 = (pb != 0);

  function automatic logic [2:0] vec_of(int s);
    return (s == 0) ? {a_in1, a_in2, a_in3} : {b_in1, b_in2, b_in3};
  endfunction
  function automatic logic rdy_of(int s);   return (s == 0) ? a_ready : b_ready;   endfunction
  function automatic logic done_of(int s);  return (s == 0) ? a_done : b_done;     endfunction
  function automatic logic mm_of(int s);    return (s == 0) ? a_mm : b_mm;         endfunction
  function automatic logic [1:0] steps_of(int s);  return (s == 0) ? a_steps : b_steps;   endfunction
  function automatic logic [1:0] sh_of(int s);     return (s == 0) ? a_shadow : b_shadow; endfunction

  task automatic set_cmd(int s, logic v, logic [1:0] t);
    if (s == 0) begin a_valid = v; a_target = t; end
    else        begin b_valid = v; b_target = t; end
  endtask

  // Issues one command and checks every cycle through to the return to IDLE.
  task automatic run_cmd(int s, int tgt);
    int st, nh, gap, after;
    gap = (s == 0) ? 0 : 2;
    st = ms[s];
    nh = 0;
    exp_q.delete();
    while (st != tgt) begin
      logic [2:0] v;
      v = hop(st, tgt);
      exp_q.push_back(v);
      nh++;
      st = partner_step(st, v);
      if (st != tgt && gap > 0 && st != 3) repeat (gap) exp_q.push_back(3'b000);
    end
    after = (tgt == 3) ? 0 : tgt;
    @(negedge clock);
    checks++;
    if (rdy_of(s) !== 1'b1) begin
      errors++; $display("FAIL ready_idle dut%0d: got %b expected 1", s, rdy_of(s));
    end
    checks++;
    if (sh_of(s) !== 2'(ms[s])) begin
      errors++; $display("FAIL shadow_idle dut%0d: got %0d expected %0d", s, sh_of(s), ms[s]);
    end
    set_cmd(s, 1'b1, 2'(tgt));
    @(posedge clock);
    #1;
    // Junk commands while busy must not be consumed.
    set_cmd(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    foreach (exp_q[i]) begin
      @(negedge clock);
      checks++;
      if (vec_of(s) !== exp_q[i]) begin
        errors++; $display("FAIL vector dut%0d tgt%0d hop%0d: got %b expected %b", s, tgt, i, vec_of(s), exp_q[i]);
      end
      checks++;
      if (done_of(s) !== 1'b0 || rdy_of(s) !== 1'b0) begin
        errors++; $display("FAIL busy_flags dut%0d: got done=%b ready=%b expected 0 0", s, done_of(s), rdy_of(s));
      end
    end
    @(negedge clock);
    checks++;
    if (done_of(s) !== 1'b1) begin
      errors++; $display("FAIL done_pulse dut%0d tgt%0d: got %b expected 1", s, tgt, done_of(s));
    end
    checks++;
    if (steps_of(s) !== 2'(nh)) begin
      errors++; $display("FAIL steps dut%0d tgt%0d: got %0d expected %0d", s, tgt, steps_of(s), nh);
    end
    checks++;
    if (sh_of(s) !== 2'(tgt) || vec_of(s) !== 3'b000) begin
      errors++; $display("FAIL at_target dut%0d: got shadow=%0d vec=%b expected %0d 000", s, sh_of(s), vec_of(s), tgt);
    end
    set_cmd(s, 1'b0, 2'd0);
    @(negedge clock);
    checks++;
    if (done_of(s) !== 1'b0 || rdy_of(s) !== 1'b1 || sh_of(s) !== 2'(after)) begin
      errors++;
      $display("FAIL post_done dut%0d: got done=%b ready=%b shadow=%0d expected 0 1 %0d",
               s, done_of(s), rdy_of(s), sh_of(s), after);
    end
    ms[s] = after;
  endtask

  task automatic test_reset();
    #2 reset_L = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (vec_of(s) !== 3'b000 || sh_of(s) !== 2'd0 || done_of(s) !== 1'b0 ||
          steps_of(s) !== 2'd0 || mm_of(s) !== 1'b0 || rdy_of(s) !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d: got vec=%b sh=%0d done=%b steps=%0d mm=%b rdy=%b expected 000 0 0 0 0 1",
                 s, vec_of(s), sh_of(s), done_of(s), steps_of(s), mm_of(s), rdy_of(s));
      end
    end
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    ms[0] = 0;
    ms[1] = 0;
  endtask

  task automatic test_single_hop();    run_cmd(0, 1); endtask
  task automatic test_multi_hop();     run_cmd(0, 3); endtask
  task automatic test_same_target();   run_cmd(0, 0); endtask
  task automatic test_idle_gap();      run_cmd(1, 3); endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      int s;
      s = n % 2;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_cmd(s, int'($urandom_range(0, 3)));
    end
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (mm_of(s) !== 1'b0) begin
        errors++; $display("FAIL no_spurious_mismatch dut%0d: got %b expected 0", s, mm_of(s));
      end
    end
  endtask

  task automatic test_reset_mid();
    if (ms[0] != 1) run_cmd(0, 1);
    @(negedge clock);
    set_cmd(0, 1'b1, 2'd3);
    @(posedge clock);
    #1 set_cmd(0, 1'b0, 2'd0);
    @(negedge clock);
    checks++;
    if (vec_of(0) !== 3'b010) begin
      errors++; $display("FAIL mid_first_hop: got %b expected 010", vec_of(0));
    end
    @(posedge clock);
    #2 reset_L = 1'b0;
    #1;
    checks++;
    if (vec_of(0) !== 3'b000 || sh_of(0) !== 2'd0 || rdy_of(0) !== 1'b1 || done_of(0) !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vec=%b sh=%0d rdy=%b done=%b expected 000 0 1 0",
               vec_of(0), sh_of(0), rdy_of(0), done_of(0));
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (done_of(0) !== 1'b0) begin
        errors++; $display("FAIL mid_reset_no_done: got %b expected 0", done_of(0));
      end
    end
    reset_L = 1'b1;
    ms[0] = 0;
    ms[1] = 0;
  endtask

  task automatic test_mismatch();
    logic exp_mm;
`ifdef FSM_STIM_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    run_cmd(0, 1);
    @(negedge clock);
    force_a = 1'b1;
    #1;
    checks++;
    if (a_mm !== 1'b0) begin
      errors++; $display("FAIL mismatch_before_edge: got %b expected 0", a_mm);
    end
    @(negedge clock);
    checks++;
    if (a_mm !== exp_mm) begin
      errors++; $display("FAIL mismatch_rise: got %b expected %b", a_mm, exp_mm);
    end
    force_a = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (a_mm !== exp_mm) begin
      errors++; $display("FAIL mismatch_sticky: got %b expected %b", a_mm, exp_mm);
    end
    reset_L = 1'b0;
    #1;
    checks++;
    if (a_mm !== 1'b0) begin
      errors++; $display("FAIL mismatch_reset: got %b expected 0", a_mm);
    end
    @(negedge clock);
    reset_L = 1'b1;
    ms[0] = 0;
    ms[1] = 0;
  endtask

  initial begin
    reset_L  = 1'b1;
    force_a  = 1'b0;
    a_valid  = 1'b0;
    a_target = 2'd0;
    b_valid  = 1'b0;
    b_target = 2'd0;
    test_reset();
    test_single_hop();
    test_multi_hop();
    test_same_target();
    test_idle_gap();
    test_back_to_back();
    test_reset_mid();
    test_mismatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
